// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph codes, active-low segment patterns and scan states shared by the seven-segment blocks.
package seven_seg_pkg;
  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  localparam logic [7:0] GLYPH_S     = 8'h0A;
  localparam logic [7:0] GLYPH_E     = 8'h0B;
  localparam logic [7:0] GLYPH_C     = 8'h0C;
  localparam logic [7:0] GLYPH_R     = 8'h0D;
  localparam logic [7:0] GLYPH_DASH  = 8'hFE;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  // Segment order {g,f,e,d,c,b,a}, 0 lights a segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/seven_seg_glyph_decode.sv
// seven_seg_glyph_decode: combinational 8-bit glyph code to active-low segment lookup.
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [7:0] i_code,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      8'h00:      o_seg = SEG_0;
      8'h01:      o_seg = SEG_1;
      8'h02:      o_seg = SEG_2;
      8'h03:      o_seg = SEG_3;
      8'h04:      o_seg = SEG_4;
      8'h05:      o_seg = SEG_5;
      8'h06:      o_seg = SEG_6;
      8'h07:      o_seg = SEG_7;
      8'h08:      o_seg = SEG_8;
      8'h09:      o_seg = SEG_9;
      GLYPH_S:    o_seg = SEG_S;
      GLYPH_E:    o_seg = SEG_E;
      GLYPH_C:    o_seg = SEG_C;
      GLYPH_R:    o_seg = SEG_R;
      GLYPH_DASH: o_seg = SEG_DASH;
      default:    o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: 8-digit multiplexed display scan with per-slot blanking and registered outputs.
// Optional SEVSEG_DIM_EN adds a dim_level input that PWM-gates the active anode.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
`ifdef SEVSEG_DIM_EN
  input  logic [2:0] dim_level,
`endif
  input  logic [7:0] ONE_DIGIT,
  output logic [2:0] refreshcounter,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_rc, w_rc_n;
  state_t        r_state, w_state_n;
  logic [7:0]    r_code, w_code_n, r_an;
  logic [6:0]    r_seg, w_seg_dec;
  logic          w_wrap, w_latch, w_show_n, w_an_on;
  seven_seg_glyph_decode u_dec (.i_code(w_code_n), .o_seg(w_seg_dec));
  always_comb begin
    w_wrap    = en && r_cnt == CW'(REFRESH_DIV - 1);
    w_latch   = en && r_cnt == CW'(BLANK_CYCLES - 1);
    w_cnt_n   = w_wrap ? '0 : en ? r_cnt + 1'b1 : r_cnt;
    w_rc_n    = w_wrap ? r_rc + 1'b1 : r_rc;
    w_state_n = w_wrap ? ST_BLANK : w_latch ? ST_SHOW : r_state;
    w_code_n  = w_latch ? ONE_DIGIT : r_code;
    w_show_n  = en && w_state_n == ST_SHOW;
  end
`ifdef SEVSEG_DIM_EN
  logic [2:0] r_pwm, w_pwm_n;
  assign w_pwm_n = r_pwm + 3'd1;
  assign w_an_on = w_show_n && w_pwm_n <= dim_level;
  always_ff @(posedge clk) r_pwm <= reset ? 3'd0 : w_pwm_n;
`else
  assign w_an_on = w_show_n;
`endif
  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rc    <= 3'd0;
      r_state <= ST_BLANK;
      r_code  <= GLYPH_BLANK;
      r_an    <= 8'hFF;
      r_seg   <= SEG_BLANK;
    end else begin
      r_cnt   <= w_cnt_n;
      r_rc    <= w_rc_n;
      r_state <= w_state_n;
      r_code  <= w_code_n;
      r_an    <= w_an_on ? ~(8'd1 << w_rc_n) : 8'hFF;
      r_seg   <= w_show_n ? w_seg_dec : SEG_BLANK;
    end
  end
  assign refreshcounter = r_rc;
  assign an             = r_an;
  assign seg            = r_seg;
  assign dp             = 1'b1;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed checks of scan timing, glyph decode, enable hold and mid-slot reset.
module tb_seven_seg_scan_driver;
  logic       clk = 1'b0, reset = 1'b1, en = 1'b1;
  logic [7:0] one_digit, ovr_val = 8'h00, exp_an;
  logic       ovr_en = 1'b0;
  logic [2:0] refreshcounter;
  logic [7:0] an;
  logic [6:0] seg, exp_seg;
  logic       dp;
  logic [7:0] digit_tab [8];
  logic [6:0] seg_tab [8];
  int         nerr = 0, nchk = 0;
  always #5 clk = ~clk;
  seven_seg_scan_driver #(.REFRESH_DIV(20), .BLANK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .en(en),
`ifdef SEVSEG_DIM_EN
    .dim_level(3'd7),
`endif
    .ONE_DIGIT(one_digit), .refreshcounter(refreshcounter), .an(an), .seg(seg), .dp(dp)
  );
  // Score 42 as the upstream formatter would present it: 2, 4, dash, S, C, O, blank, blank.
  always_comb one_digit = ovr_en ? ovr_val : digit_tab[refreshcounter];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    digit_tab = '{8'h02, 8'h04, 8'hFE, 8'h0A, 8'h0C, 8'h00, 8'hFF, 8'hFF};
    seg_tab   = '{7'h24, 7'h19, 7'h3F, 7'h12, 7'h46, 7'h40, 7'h7F, 7'h7F};
    tick();
    tick();
    chk("reset_an", an, 8'hFF);
    chk("reset_rc", refreshcounter, 0);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1);
    reset = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      tick();
      exp_an  = (c % 20 < 4) ? 8'hFF : ~(8'd1 << ((c / 20) % 8));
      exp_seg = (c % 20 < 4) ? 7'h7F : seg_tab[(c / 20) % 8];
      chk($sformatf("scan_an_c%0d", c), an, exp_an);
      chk($sformatf("scan_seg_c%0d", c), seg, exp_seg);
      chk($sformatf("scan_rc_c%0d", c), refreshcounter, (c / 20) % 8);
    end
    chk("wrap160_rc", refreshcounter, 0);
    ovr_en  = 1'b1;
    ovr_val = 8'h03;
    repeat (4) tick();
    chk("toggle_seg3", seg, 7'h30);
    repeat (4) tick();
    ovr_val = 8'h08;
    repeat (11) tick();
    chk("toggle_hold_c19", seg, 7'h30);
    chk("toggle_an_c19", an, 8'hFE);
    tick();
    chk("toggle_blank_seg", seg, 7'h7F);
    repeat (4) tick();
    chk("toggle_next_seg8", seg, 7'h00);
    ovr_en = 1'b0;
    repeat (46) tick();
    chk("pre_en_rc", refreshcounter, 3);
    chk("pre_en_an", an, 8'hF7);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("en_off_an_%0d", i), an, 8'hFF);
      chk($sformatf("en_off_seg_%0d", i), seg, 7'h7F);
      chk($sformatf("en_off_rc_%0d", i), refreshcounter, 3);
    end
    en = 1'b1;
    for (int i = 11; i <= 19; i++) begin
      tick();
      chk($sformatf("resume_an_cnt%0d", i), an, 8'hF7);
      chk($sformatf("resume_seg_cnt%0d", i), seg, 7'h12);
    end
    tick();
    chk("resume_wrap_an", an, 8'hFF);
    chk("resume_wrap_rc", refreshcounter, 4);
    repeat (30) tick();
    chk("pre_rst_rc", refreshcounter, 5);
    chk("pre_rst_an", an, 8'hDF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_rc", refreshcounter, 0);
    chk("midrst_an", an, 8'hFF);
    chk("midrst_seg", seg, 7'h7F);
    repeat (3) tick();
    chk("midrst_c3_an", an, 8'hFF);
    tick();
    chk("midrst_c4_an", an, 8'hFE);
    chk("midrst_c4_seg", seg, 7'h24);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
